rnn_mem_responder: RTL and testbench

Synthesizable responder for the RNN core's memory and input-stream ports, replacing the behavioural bench model in silicon. Serves `mce`/`msel`/`maddr` reads from a shared synchronous weight/bias SRAM, returns the sequence length, and queues result writes into an output FIFO drained by the host. It also streams input vectors to `idata` on `i_en` and sequences the core's `ready`/`busy` handshake for one run.

---
 rtl/rnn_mem_responder_if.sv | 26 ++
 rtl/rnn_mem_responder.sv | 197 +++++++++++++++++++
 tb/tb_rnn_mem_responder.sv | 233 +++++++++++++++++++++++
 3 files changed

// File: rtl/rnn_mem_responder_if.sv
// Core-side bundle of rnn_mem_responder: memory request/response, input stream and ready/busy handshake.
interface rnn_mem_responder_if #(
    parameter int unsigned DW = 20,
    parameter int unsigned AW = 17,
    parameter int unsigned IW = 32
);
    logic          mce;
    logic [2:0]    msel;
    logic [AW-1:0] maddr;
    logic [DW-1:0] mdata_w;
    logic [DW-1:0] mdata_r;
    logic          i_en;
    logic [IW-1:0] idata;
    logic          rnn_ready;
    logic          rnn_busy;

    modport master (
        output mce, msel, maddr, mdata_w, i_en, rnn_busy,
        input  mdata_r, idata, rnn_ready
    );

    modport slave (
        input  mce, msel, maddr, mdata_w, i_en, rnn_busy,
        output mdata_r, idata, rnn_ready
    );
endinterface

// File: rtl/rnn_mem_responder.sv
// Memory/input-stream responder for the RNN core: SRAM read mux, result FIFO, input buffer, run handshake.
// Optional address range checking is enabled by defining RNN_MEMSRV_BOUNDS_CHECK_EN.
module rnn_mem_responder #(
    parameter int unsigned DW         = 20,
    parameter int unsigned AW         = 17,
    parameter int unsigned IW         = 32,
    parameter int unsigned FIFO_DEPTH = 16,
    parameter int unsigned SEQ_LEN    = 200,
    parameter int unsigned N_IH       = 2048,
    parameter int unsigned N_HH       = 4096,
    parameter int unsigned N_HID      = 64
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start,
    output logic                 done,
    rnn_mem_responder_if.slave   core,
    output logic                 sram_re,
    output logic [1:0]           sram_sel,
    output logic [11:0]          sram_addr,
    input  logic [DW-1:0]        sram_rdata,
    input  logic                 in_valid,
    input  logic [IW-1:0]        in_data,
    output logic                 in_ready,
    output logic                 out_valid,
    output logic [AW-1:0]        out_addr,
    output logic [DW-1:0]        out_data,
    input  logic                 out_ready,
    output logic                 overflow,
    output logic                 underrun,
    output logic                 err
);
    localparam int unsigned FAW   = $clog2(FIFO_DEPTH);
    localparam int unsigned CW    = $clog2(FIFO_DEPTH + 1);
    localparam int unsigned SW    = $clog2(SEQ_LEN + 1);
    localparam int unsigned WR_LIM = N_HID * SEQ_LEN;
`ifdef RNN_MEMSRV_BOUNDS_CHECK_EN
    localparam bit BOUNDS_EN = 1'b1;
`else
    localparam bit BOUNDS_EN = 1'b0;
`endif

    typedef struct packed {
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
    } res_t;

    typedef enum logic [2:0] {S_IDLE, S_ARM, S_RUN, S_DRAIN, S_DONE} state_t;
    typedef enum logic [1:0] {RD_NONE, RD_SRAM, RD_SEQ, RD_ZERO} rd_t;

    state_t state, state_n;
    rd_t    rd_kind;
    logic   start_go, fifo_empty;

    // Run sequencing
    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= S_IDLE;
        else       state <= state_n;
    end

    always_comb begin
        state_n = state;
        case (state)
            S_IDLE:  if (start)          state_n = S_ARM;
            S_ARM:   if (core.rnn_busy)  state_n = S_RUN;
            S_RUN:   if (!core.rnn_busy) state_n = S_DRAIN;
            S_DRAIN: if (fifo_empty)     state_n = S_DONE;
            S_DONE:                      state_n = S_IDLE;
            default:                     state_n = S_IDLE;
        endcase
    end

    assign start_go = start && (state == S_IDLE);

    // Request decode and optional range checks
    logic        rd_req, wr_req, seq_req, rd_oob, wr_oob;
    logic [31:0] rd_lim;

    always_comb begin
        rd_req  = core.mce && !core.msel[2];
        seq_req = core.mce && (core.msel == 3'd4);
        wr_req  = core.mce && (core.msel == 3'd5);
        case (core.msel[1:0])
            2'd0:    rd_lim = N_IH;
            2'd1:    rd_lim = N_HID;
            2'd2:    rd_lim = N_HH;
            default: rd_lim = N_HID;
        endcase
        rd_oob = BOUNDS_EN && rd_req && (32'(core.maddr) >= rd_lim);
        wr_oob = BOUNDS_EN && wr_req && (32'(core.maddr) >= WR_LIM);
    end

    assign sram_re   = rd_req && !rd_oob;
    assign sram_sel  = core.msel[1:0];
    assign sram_addr = core.maddr[11:0];

    // Result FIFO bookkeeping; out_* is a registered copy of the next head
    res_t            mem [FIFO_DEPTH];
    res_t            push_entry, head_n;
    logic [FAW-1:0]  wr_ptr, rd_ptr, rd_ptr_n;
    logic [CW-1:0]   count, count_n;
    logic            full, pop, push_try, push, ovf_set;

    always_comb begin
        push_entry = '{addr: core.maddr, data: core.mdata_w};
        full       = (count == CW'(FIFO_DEPTH));
        fifo_empty = (count == '0);
        pop        = out_valid && out_ready;
        push_try   = wr_req && !wr_oob;
        push       = push_try && (!full || pop);
        ovf_set    = push_try && full && !pop;
        count_n    = count + CW'(push) - CW'(pop);
        rd_ptr_n   = rd_ptr + FAW'(pop);
        head_n     = (push && (wr_ptr == rd_ptr_n)) ? push_entry : mem[rd_ptr_n];
    end

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= push_entry;
    end

    // Input buffer bookkeeping
    logic [IW-1:0] ib [2];
    logic          ib_wr, ib_rd, acc, ipop, urun_set;
    logic [1:0]    ib_cnt, ib_cnt_n;
    logic [SW-1:0] acc_cnt, acc_cnt_n;

    always_comb begin
        acc       = in_valid && in_ready;
        ipop      = core.i_en && (ib_cnt != 2'd0);
        urun_set  = core.i_en && (ib_cnt == 2'd0);
        ib_cnt_n  = ib_cnt + 2'(acc) - 2'(ipop);
        acc_cnt_n = start_go ? '0 : acc_cnt + SW'(acc);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            core.rnn_ready <= 1'b0;
            done           <= 1'b0;
            rd_kind        <= RD_NONE;
            core.mdata_r   <= '0;
            wr_ptr         <= '0;
            rd_ptr         <= '0;
            count          <= '0;
            out_valid      <= 1'b0;
            out_addr       <= '0;
            out_data       <= '0;
            ib[0]          <= '0;
            ib[1]          <= '0;
            ib_wr          <= 1'b0;
            ib_rd          <= 1'b0;
            ib_cnt         <= '0;
            acc_cnt        <= '0;
            in_ready       <= 1'b0;
            core.idata     <= '0;
            overflow       <= 1'b0;
            underrun       <= 1'b0;
            err            <= 1'b0;
        end else begin
            core.rnn_ready <= (state_n == S_ARM);
            done           <= (state_n == S_DONE);

            // SRAM data is captured one edge after the request
            if (rd_req)       rd_kind <= rd_oob ? RD_ZERO : RD_SRAM;
            else if (seq_req) rd_kind <= RD_SEQ;
            else              rd_kind <= RD_NONE;
            case (rd_kind)
                RD_SRAM: core.mdata_r <= sram_rdata;
                RD_SEQ:  core.mdata_r <= DW'(SEQ_LEN);
                RD_ZERO: core.mdata_r <= '0;
                default: core.mdata_r <= core.mdata_r;
            endcase

            if (push) wr_ptr <= wr_ptr + FAW'(1);
            rd_ptr    <= rd_ptr_n;
            count     <= count_n;
            out_valid <= (count_n != '0);
            out_addr  <= head_n.addr;
            out_data  <= head_n.data;

            if (acc) begin
                ib[ib_wr] <= in_data;
                ib_wr     <= ~ib_wr;
            end
            if (ipop) begin
                core.idata <= ib[ib_rd];
                ib_rd      <= ~ib_rd;
            end
            ib_cnt   <= ib_cnt_n;
            acc_cnt  <= acc_cnt_n;
            in_ready <= (ib_cnt_n != 2'd2) && (acc_cnt_n < SW'(SEQ_LEN));

            overflow <= (overflow && !start_go) || ovf_set;
            underrun <= (underrun && !start_go) || urun_set;
            err      <= (err && !start_go) || rd_oob || wr_oob;
        end
    end
endmodule

// File: tb/tb_rnn_mem_responder.sv
// Directed self-checking bench for rnn_mem_responder (SRAM model returns {sel,addr}).
module tb_rnn_mem_responder;
    localparam int unsigned DW = 20;
    localparam int unsigned AW = 17;
    localparam int unsigned IW = 32;

    logic          clk = 1'b0;
    logic          reset, start, done;
    logic          sram_re;
    logic [1:0]    sram_sel;
    logic [11:0]   sram_addr;
    logic [DW-1:0] sram_rdata = '0;
    logic          in_valid, in_ready;
    logic [IW-1:0] in_data;
    logic          out_valid, out_ready;
    logic [AW-1:0] out_addr;
    logic [DW-1:0] out_data;
    logic          overflow, underrun, err;

    int n_cmp = 0;
    int n_err = 0;

    rnn_mem_responder_if #(.DW(DW), .AW(AW), .IW(IW)) core_if ();

    rnn_mem_responder dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .done       (done),
        .core       (core_if),
        .sram_re    (sram_re),
        .sram_sel   (sram_sel),
        .sram_addr  (sram_addr),
        .sram_rdata (sram_rdata),
        .in_valid   (in_valid),
        .in_data    (in_data),
        .in_ready   (in_ready),
        .out_valid  (out_valid),
        .out_addr   (out_addr),
        .out_data   (out_data),
        .out_ready  (out_ready),
        .overflow   (overflow),
        .underrun   (underrun),
        .err        (err)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (sram_re) sram_rdata <= DW'({sram_sel, sram_addr});
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic mem_req(input logic ce, input logic [2:0] sel, input logic [AW-1:0] addr,
                           input logic [DW-1:0] wdata);
        core_if.mce     = ce;
        core_if.msel    = sel;
        core_if.maddr   = addr;
        core_if.mdata_w = wdata;
    endtask

    initial begin
        logic [31:0] q[$];
        logic [31:0] exp_idata;
        logic [31:0] d;
        logic        acc_now, pop_now;
        int          sent, cyc;

        reset = 1'b1; start = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
        core_if.rnn_busy = 1'b0; core_if.i_en = 1'b0;
        mem_req(1'b0, 3'd0, '0, '0);
        exp_idata = '0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_mdata_r", core_if.mdata_r, 0);
        check("rst_idata", core_if.idata, 0);
        check("rst_rnn_ready", core_if.rnn_ready, 0);
        check("rst_done", done, 0);
        check("rst_out_valid", out_valid, 0);
        check("rst_in_ready", in_ready, 0);
        check("rst_flags", {overflow, underrun, err}, 0);
        reset = 1'b0;
        tick();

        // Handshake
        start = 1'b1; tick(); start = 1'b0;
        check("hs_ready_set", core_if.rnn_ready, 1);
        core_if.rnn_busy = 1'b1; tick();
        check("hs_ready_clr", core_if.rnn_ready, 0);
        core_if.rnn_busy = 1'b0; tick();
        check("hs_done_early", done, 0);
        tick();
        check("hs_done_pulse", done, 1);
        tick();
        check("hs_done_end", done, 0);

        // Read mux
        mem_req(1'b1, 3'd2, AW'(17'h0007F), '0); #1;
        check("rd2_re", sram_re, 1);
        check("rd2_sel", sram_sel, 2);
        check("rd2_addr", sram_addr, 12'h07F);
        tick(); mem_req(1'b0, 3'd0, '0, '0); tick();
        check("rd2_data", core_if.mdata_r, 20'h0207F);
        mem_req(1'b1, 3'd0, AW'(17'h01ABC), '0); #1;
        check("rd0_addr", sram_addr, 12'hABC);
        tick(); mem_req(1'b0, 3'd0, '0, '0); tick();
        check("rd0_data", core_if.mdata_r, 20'h00ABC);
        mem_req(1'b1, 3'd4, '0, '0); tick(); mem_req(1'b0, 3'd0, '0, '0); tick();
        check("seq_len", core_if.mdata_r, 200);
        mem_req(1'b1, 3'd6, AW'(17'h00010), '0); #1;
        check("sel6_no_re", sram_re, 0);
        tick(); mem_req(1'b0, 3'd0, '0, '0); tick();
        check("sel6_hold", core_if.mdata_r, 200);

        // Region bounds
        mem_req(1'b1, 3'd1, AW'(17'd64), '0); #1;
`ifdef RNN_MEMSRV_BOUNDS_CHECK_EN
        check("bnd_re", sram_re, 0);
        tick(); mem_req(1'b0, 3'd0, '0, '0); tick();
        check("bnd_data", core_if.mdata_r, 0);
        check("bnd_err", err, 1);
`else
        check("bnd_re", sram_re, 1);
        tick(); mem_req(1'b0, 3'd0, '0, '0); tick();
        check("bnd_data", core_if.mdata_r, 20'h01040);
        check("bnd_err", err, 0);
`endif

        // Result FIFO: fill, push+pop while full, overflow, drain
        out_ready = 1'b0;
        for (int i = 0; i < 16; i++) begin
            mem_req(1'b1, 3'd5, AW'(32'h100 + 32'(i)), DW'(32'h5000 + 32'(i)));
            tick();
        end
        check("fifo_valid", out_valid, 1);
        check("fifo_head_addr", out_addr, 17'h00100);
        check("fifo_ovf_full", overflow, 0);
        mem_req(1'b1, 3'd5, AW'(17'h00110), DW'(20'h05010)); out_ready = 1'b1;
        tick();
        check("fifo_pushpop_ovf", overflow, 0);
        out_ready = 1'b0;
        mem_req(1'b1, 3'd5, AW'(17'h001EE), DW'(20'hABCDE));
        tick();
        mem_req(1'b0, 3'd0, '0, '0);
        check("fifo_ovf", overflow, 1);
        out_ready = 1'b1;
        for (int k = 0; k < 16; k++) begin
            check("drain_valid", out_valid, 1);
            check("drain_addr", out_addr, 32'h101 + 32'(k));
            check("drain_data", out_data, 32'h5001 + 32'(k));
            tick();
        end
        check("drain_empty", out_valid, 0);
        out_ready = 1'b0;

        // Start clears sticky flags
        start = 1'b1; tick(); start = 1'b0;
        check("start_clr_ovf", overflow, 0);
        check("start_ready", core_if.rnn_ready, 1);

        // Input stream with a bench-side buffer model
        sent = 0; cyc = 0;
        while (sent < 200 && cyc < 2000) begin
            d = 32'hC0DE_0000 + 32'(sent);
            in_valid = 1'b1; in_data = d;
            core_if.i_en = (q.size() > 0) && (cyc % 3 != 0);
            acc_now = in_ready; pop_now = core_if.i_en;
            tick();
            if (pop_now) begin
                exp_idata = q.pop_front();
                check("idata", core_if.idata, exp_idata);
            end
            if (acc_now) begin
                q.push_back(d);
                sent++;
            end
            cyc++;
        end
        in_valid = 1'b0; core_if.i_en = 1'b0;
        check("in_accepted", sent, 200);
        check("in_ready_stop", in_ready, 0);
        cyc = 0;
        while (q.size() > 0 && cyc < 10) begin
            core_if.i_en = 1'b1; tick();
            exp_idata = q.pop_front();
            check("idata_drain", core_if.idata, exp_idata);
            cyc++;
        end
        core_if.i_en = 1'b0; tick();
        check("in_ready_held", in_ready, 0);
        check("no_underrun", underrun, 0);
        core_if.i_en = 1'b1; tick(); core_if.i_en = 1'b0;
        check("underrun", underrun, 1);
        check("idata_hold", core_if.idata, exp_idata);

        // Reset in RUN with 5 queued results
        core_if.rnn_busy = 1'b1; tick();
        check("run_ready_clr", core_if.rnn_ready, 0);
        for (int i = 0; i < 5; i++) begin
            mem_req(1'b1, 3'd5, AW'(32'h200 + 32'(i)), DW'(i));
            tick();
        end
        mem_req(1'b0, 3'd0, '0, '0);
        check("run_fifo_valid", out_valid, 1);
        @(negedge clk);
        reset = 1'b1; #1;
        check("abort_out_valid", out_valid, 0);
        check("abort_underrun", underrun, 0);
        core_if.rnn_busy = 1'b0;
        tick();
        reset = 1'b0;
        tick();
        check("post_rst_empty", out_valid, 0);
        check("post_rst_idle", core_if.rnn_ready, 0);
        start = 1'b1; tick(); start = 1'b0;
        check("post_rst_arm", core_if.rnn_ready, 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
